lsu_ctrl: RTL and testbench

Core-side load/store initiator for the 3-stage pipeline. It accepts one load or store per handshake from the execute stage and drives the word-organised data memory port with byte enables. Accesses that cross a word boundary are split into two beats. Load data is aligned and sign- or zero-extended per RISC-V funct3, then returned with a one-cycle response pulse. While an access is in flight, `busy` stalls the pipeline.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and access-size / legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_CAP,
        ST_RESP
    } lsu_state_e;

    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        logic [2:0] n;
        case (funct3[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Stores only check the unsigned bit; loads reject the three unused codes.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = !funct3[2];
        end else begin
            ok = !(funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed bytes from the two captured words and applies
// sign or zero extension according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [31:0] window;
    logic        unused_hi;

    // The largest offset is 3 bytes, so the top byte is never selected.
    assign unused_hi = ^data_i[63:56];

    always_comb begin
        window = data_i[{off_i, 3'b000} +: 32];
        case (funct3_i)
            F3_B:    result_o = {{24{window[7]}}, window[7:0]};
            F3_H:    result_o = {{16{window[15]}}, window[15:0]};
            F3_BU:   result_o = {24'b0, window[7:0]};
            F3_HU:   result_o = {16'b0, window[15:0]};
            default: result_o = window;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: splits misaligned accesses into two word beats,
// positions store data on byte lanes and returns aligned, extended load data.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                busy,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    lsu_state_e state_q, state_d;

    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   buf0_q, buf0_d;
    logic [DATA_W-1:0]   buf1_q, buf1_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W/8-1:0] mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    // In IDLE the beat-0 outputs are registered straight from the request.
    logic                cur_we;
    logic [2:0]          cur_funct3;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [2:0]          nbytes;
    logic [7:0]          mask8;
    logic [7:0]          be8;
    logic                split;
    logic [2*DATA_W-1:0] wd64;
    logic [ADDR_W-1:0]   beat0_addr;
    logic [ADDR_W-1:0]   beat1_addr;
    logic [2*DATA_W-1:0] align_in;
    logic [31:0]         ld_result;

    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we     = req_we;
            cur_funct3 = req_funct3;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = we_q;
            cur_funct3 = funct3_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
        end
        nbytes     = size_bytes(cur_funct3);
        mask8      = (8'd1 << nbytes) - 8'd1;
        be8        = mask8 << cur_addr[1:0];
        split      = |be8[7:4];
        wd64       = {{DATA_W{1'b0}}, cur_wdata} << {cur_addr[1:0], 3'b000};
        beat0_addr = {cur_addr[ADDR_W-1:2], 2'b00};
        beat1_addr = {cur_addr[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
    end

    // Data the buffers will hold at the end of CAP, fed to the aligner so the
    // response can be registered on the same edge.
    assign align_in = split ? {mem_rdata, buf0_q} : {{DATA_W{1'b0}}, mem_rdata};

    lsu_load_align u_align (
        .data_i   (align_in),
        .off_i    (addr_q[1:0]),
        .funct3_i (funct3_q),
        .result_o (ld_result)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        buf0_d       = buf0_q;
        buf1_d       = buf1_q;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    buf0_d   = '0;
                    buf1_d   = '0;
                    if (!is_legal(req_we, req_funct3)) begin
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d = ST_ACC0;
                    end
                end
            end
            ST_ACC0: begin
                if (split) begin
                    state_d = ST_ACC1;
                end else begin
                    state_d = we_q ? ST_RESP : ST_CAP;
                end
            end
            ST_ACC1: begin
                if (!we_q) begin
                    buf0_d = mem_rdata;
                end
                state_d = we_q ? ST_RESP : ST_CAP;
            end
            ST_CAP: begin
                if (split) begin
                    buf1_d = mem_rdata;
                end else begin
                    buf0_d = mem_rdata;
                end
                resp_rdata_d = ld_result;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        resp_valid_d = (state_d == ST_RESP);
    end

    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = '0;
        if (state_d == ST_ACC0) begin
            mem_en_d    = 1'b1;
            mem_we_d    = cur_we;
            mem_be_d    = be8[3:0];
            mem_addr_d  = beat0_addr;
            mem_wdata_d = wd64[DATA_W-1:0];
        end else if (state_d == ST_ACC1) begin
            mem_en_d    = 1'b1;
            mem_we_d    = cur_we;
            mem_be_d    = be8[7:4];
            mem_addr_d  = beat1_addr;
            mem_wdata_d = wd64[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a synchronous-read word memory model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // 64-word memory; only address bits [7:2] are decoded.
    logic [31:0] mem [0:63];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = data;
        step();
        bd_we   = 1'b0;
    endtask

    int          lat;
    int          nbeats;
    logic        got;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] b_addr [2];
    logic [3:0]  b_be   [2];
    logic [31:0] b_wd   [2];

    // Issues one request and follows it to the response pulse, recording beats.
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
        lat        = 0;
        nbeats     = 0;
        got        = 1'b0;
        r_rdata    = 32'hx;
        r_err      = 1'bx;
        for (int i = 0; i < 2; i++) begin
            b_addr[i] = 32'hx;
            b_be[i]   = 4'hx;
            b_wd[i]   = 32'hx;
        end
        for (int c = 1; c <= 10 && !got; c++) begin
            if (mem_en) begin
                if (nbeats < 2) begin
                    b_addr[nbeats] = mem_addr;
                    b_be[nbeats]   = mem_be;
                    b_wd[nbeats]   = mem_wdata;
                end
                nbeats++;
            end
            if (resp_valid) begin
                got     = 1'b1;
                lat     = c;
                r_rdata = resp_rdata;
                r_err   = resp_err;
            end
            step();
        end
        chk("resp_seen", 32'(got), 32'd1);
        $display("txn we=%0d f3=%03b addr=%08h wdata=%08h lat=%0d beats=%0d rdata=%08h err=%0d",
                 we, f3, addr, wd, lat, nbeats, r_rdata, r_err);
    endtask

    logic saw;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        bd_we      = 1'b0;
        bd_idx     = 6'd0;
        bd_data    = 32'h0;
        repeat (3) step();

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        step();

        // SW 0x10: one beat, response two cycles after accept
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h10;
        req_wdata  = 32'hDEADBEEF;
        step();
        req_valid  = 1'b0;
        chk("sw_t1_busy", 32'(busy), 32'd1);
        chk("sw_t1_mem_en", 32'(mem_en), 32'd1);
        chk("sw_t1_mem_we", 32'(mem_we), 32'd1);
        chk("sw_t1_be", 32'(mem_be), 32'hF);
        chk("sw_t1_addr", mem_addr, 32'h10);
        chk("sw_t1_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_t1_resp_valid", 32'(resp_valid), 32'd0);
        step();
        chk("sw_t2_resp_valid", 32'(resp_valid), 32'd1);
        chk("sw_t2_resp_err", 32'(resp_err), 32'd0);
        chk("sw_t2_rdata", resp_rdata, 32'h0);
        chk("sw_t2_busy", 32'(busy), 32'd1);
        chk("sw_t2_mem_en", 32'(mem_en), 32'd0);
        chk("sw_t2_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("sw_t3_resp_valid", 32'(resp_valid), 32'd0);
        chk("sw_t3_busy", 32'(busy), 32'd0);
        chk("sw_t3_mem_word", mem[4], 32'hDEADBEEF);
        $display("txn we=1 f3=010 addr=00000010 wdata=deadbeef checked cycle by cycle");

        // LB / LBU at 0x13 of 0x80AABBCC
        poke(6'd4, 32'h80AABBCC);
        run_req(1'b0, F3_B, 32'h13, 32'h0);
        chk("lb_lat", 32'(lat), 32'd3);
        chk("lb_beats", 32'(nbeats), 32'd1);
        chk("lb_addr", b_addr[0], 32'h10);
        chk("lb_be", 32'(b_be[0]), 32'h8);
        chk("lb_rdata", r_rdata, 32'hFFFFFF80);
        chk("lb_err", 32'(r_err), 32'd0);
        run_req(1'b0, F3_BU, 32'h13, 32'h0);
        chk("lbu_rdata", r_rdata, 32'h00000080);

        // LH / LHU at 0x13 spanning two words
        poke(6'd4, 32'h11223344);
        poke(6'd5, 32'h55667788);
        run_req(1'b0, F3_H, 32'h13, 32'h0);
        chk("lh_lat", 32'(lat), 32'd4);
        chk("lh_beats", 32'(nbeats), 32'd2);
        chk("lh_addr0", b_addr[0], 32'h10);
        chk("lh_be0", 32'(b_be[0]), 32'h8);
        chk("lh_addr1", b_addr[1], 32'h14);
        chk("lh_be1", 32'(b_be[1]), 32'h1);
        chk("lh_rdata", r_rdata, 32'hFFFF8811);
        run_req(1'b0, F3_HU, 32'h13, 32'h0);
        chk("lhu_rdata", r_rdata, 32'h00008811);

        // Split SW at 0x0E, then read it back as a split LW
        poke(6'd3, 32'h0);
        poke(6'd4, 32'h0);
        run_req(1'b1, F3_W, 32'h0E, 32'hAABBCCDD);
        chk("sws_lat", 32'(lat), 32'd3);
        chk("sws_beats", 32'(nbeats), 32'd2);
        chk("sws_addr0", b_addr[0], 32'h0C);
        chk("sws_be0", 32'(b_be[0]), 32'hC);
        chk("sws_wd0", b_wd[0], 32'hCCDD0000);
        chk("sws_addr1", b_addr[1], 32'h10);
        chk("sws_be1", 32'(b_be[1]), 32'h3);
        chk("sws_wd1", b_wd[1], 32'h0000AABB);
        chk("sws_rdata", r_rdata, 32'h0);
        run_req(1'b0, F3_W, 32'h0E, 32'h0);
        chk("lws_lat", 32'(lat), 32'd4);
        chk("lws_rdata", r_rdata, 32'hAABBCCDD);

        // Illegal encodings never touch memory
        run_req(1'b0, 3'b011, 32'h10, 32'h0);
        chk("ill_ld_lat", 32'(lat), 32'd1);
        chk("ill_ld_err", 32'(r_err), 32'd1);
        chk("ill_ld_rdata", r_rdata, 32'h0);
        chk("ill_ld_beats", 32'(nbeats), 32'd0);
        run_req(1'b1, 3'b100, 32'h10, 32'h12345678);
        chk("ill_st_lat", 32'(lat), 32'd1);
        chk("ill_st_err", 32'(r_err), 32'd1);
        chk("ill_st_rdata", r_rdata, 32'h0);
        chk("ill_st_beats", 32'(nbeats), 32'd0);

        // Reset during ACC1 of a split store abandons it
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h0E;
        req_wdata  = 32'hAABBCCDD;
        step();
        req_valid  = 1'b0;
        step();
        chk("rst_acc1_be", 32'(mem_be), 32'h3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid) saw = 1'b1;
            step();
        end
        chk("rst_mid_no_resp", 32'(saw), 32'd0);
        $display("txn reset during split store acc1 resp_seen=%0d", saw);

        // Beat 1 address wraps to zero
        run_req(1'b1, F3_W, 32'hFFFFFFFE, 32'h12345678);
        chk("wrap_lat", 32'(lat), 32'd3);
        chk("wrap_addr0", b_addr[0], 32'hFFFFFFFC);
        chk("wrap_be0", 32'(b_be[0]), 32'hC);
        chk("wrap_addr1", b_addr[1], 32'h00000000);
        chk("wrap_be1", 32'(b_be[1]), 32'h3);
        chk("wrap_wd1", b_wd[1], 32'h00001234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
